adbg_cpu_halt_group_ctrl: RTL and testbench

- Sequences cross-core halt and resume for the per-core CPU debug modules. Sits between the NB_CORES CPU debug modules and the cores' stall inputs.
- When any core in the halt group hits a breakpoint, or the debugger issues a group halt, every core in the group is stalled. The block then waits for each core to acknowledge the halt.
- Later it releases the group on a resume request and waits for every core to leave the halted state.
- A timeout counter bounds both waits, so an unresponsive core cannot hang the debugger.

---
 rtl/adbg_cpu_halt_group_ctrl.sv | 178 +++++++++++++++++
 tb/tb_adbg_cpu_halt_group_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adbg_cpu_halt_group_ctrl.sv
// ----------------------------------------------------------------------------
// adbg_cpu_halt_group_ctrl
//
// Cross-core halt/resume sequencer for a group of CPU debug modules. A
// breakpoint on any group member, or a debugger group halt request, stalls
// every core in the group. The block then waits for every member to report
// halted, and later releases the group on a resume request and waits for
// every member to leave the halted state. A shared wait counter bounds both
// waits so that an unresponsive core cannot hang the debugger.
//
// Ports:
//   cpu_clk_i        block clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   group_mask_i     cores in the halt group (captured at the trigger only)
//   dbg_stall_req_i  per-core manual stall from the debug modules (level)
//   cpu_bp_i         per-core breakpoint/trap indication (level)
//   cpu_halted_i     per-core "halted" acknowledge
//   halt_req_i       one-cycle group halt request
//   resume_req_i     one-cycle group resume request
//   cpu_stall_o      stall to each core
//   group_state_o    0=RUN, 1=HALTING, 2=HALTED, 3=RESUMING
//   halt_set_o       group mask captured at the trigger
//   bp_cause_o       sticky record of group cores that raised a breakpoint
//   timeout_o        sticky: the last HALTING/RESUMING wait expired
//   busy_o           high while HALTING or RESUMING
// ----------------------------------------------------------------------------
module adbg_cpu_halt_group_ctrl #(
    parameter int NB_CORES     = 4,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                cpu_clk_i,
    input  logic                rst_i,
    input  logic [NB_CORES-1:0] group_mask_i,
    input  logic [NB_CORES-1:0] dbg_stall_req_i,
    input  logic [NB_CORES-1:0] cpu_bp_i,
    input  logic [NB_CORES-1:0] cpu_halted_i,
    input  logic                halt_req_i,
    input  logic                resume_req_i,
    output logic [NB_CORES-1:0] cpu_stall_o,
    output logic [1:0]          group_state_o,
    output logic [NB_CORES-1:0] halt_set_o,
    output logic [NB_CORES-1:0] bp_cause_o,
    output logic                timeout_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
    // Last counter value of a wait: the wait lasts exactly HALT_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [NB_CORES-1:0] MASK_ZERO = {NB_CORES{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTING  = 2'd1,
        ST_HALTED   = 2'd2,
        ST_RESUMING = 2'd3
    } state_t;

    state_t              state_r;
    logic [NB_CORES-1:0] halt_set_r;
    logic [NB_CORES-1:0] bp_cause_r;
    logic                timeout_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                trig_s;
    logic [NB_CORES-1:0] grp_bp_s;
    logic [NB_CORES-1:0] new_bp_s;
    logic                all_halted_s;
    logic                none_halted_s;

    // Every member of the set has acknowledged the halt (true for an empty set).
    function automatic logic all_acked(input logic [NB_CORES-1:0] halted,
                                       input logic [NB_CORES-1:0] set);
        return ((halted & set) == set);
    endfunction

    // No member of the set still reports halted.
    function automatic logic none_acked(input logic [NB_CORES-1:0] halted,
                                        input logic [NB_CORES-1:0] set);
        return ((halted & set) == {NB_CORES{1'b0}});
    endfunction

    // Trigger and handshake decode from the current inputs and captured set.
    always_comb begin
        grp_bp_s      = cpu_bp_i & group_mask_i;
        new_bp_s      = cpu_bp_i & halt_set_r;
        trig_s        = halt_req_i | (|grp_bp_s);
        all_halted_s  = all_acked(cpu_halted_i, halt_set_r);
        none_halted_s = none_acked(cpu_halted_i, halt_set_r);
    end

    // Group sequencer: state, captured set, breakpoint cause, timeout, counter.
    always_ff @(posedge cpu_clk_i) begin
        if (rst_i) begin
            state_r    <= ST_RUN;
            halt_set_r <= MASK_ZERO;
            bp_cause_r <= MASK_ZERO;
            timeout_r  <= 1'b0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (trig_s) begin
                        state_r    <= ST_HALTING;
                        halt_set_r <= group_mask_i;
                        bp_cause_r <= grp_bp_s;
                        timeout_r  <= 1'b0;
                        cnt_r      <= '0;
                    end
                end
                ST_HALTING: begin
                    bp_cause_r <= bp_cause_r | new_bp_s;
                    cnt_r      <= cnt_r + CNT_ONE;
                    // A complete acknowledge wins over an expiring counter.
                    if (all_halted_s) begin
                        state_r <= ST_HALTED;
                        cnt_r   <= '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= ST_HALTED;
                        timeout_r <= 1'b1;
                        cnt_r     <= '0;
                    end
                end
                ST_HALTED: begin
                    bp_cause_r <= bp_cause_r | new_bp_s;
                    // halt_req_i has no effect here, so resume wins a tie.
                    if (resume_req_i) begin
                        state_r   <= ST_RESUMING;
                        timeout_r <= 1'b0;
                        cnt_r     <= '0;
                    end
                end
                ST_RESUMING: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (none_halted_s) begin
                        state_r    <= ST_RUN;
                        halt_set_r <= MASK_ZERO;
                        cnt_r      <= '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r    <= ST_RUN;
                        halt_set_r <= MASK_ZERO;
                        timeout_r  <= 1'b1;
                        cnt_r      <= '0;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    halt_set_r <= MASK_ZERO;
                    bp_cause_r <= MASK_ZERO;
                    timeout_r  <= 1'b0;
                    cnt_r      <= '0;
                end
            endcase
        end
    end

    // Output decode: group stall applies only while the group is being held.
    always_comb begin
        cpu_stall_o = dbg_stall_req_i;
        busy_o      = 1'b0;
        if ((state_r == ST_HALTING) || (state_r == ST_HALTED)) begin
            cpu_stall_o = dbg_stall_req_i | halt_set_r;
        end else begin
            cpu_stall_o = dbg_stall_req_i;
        end
        if ((state_r == ST_HALTING) || (state_r == ST_RESUMING)) begin
            busy_o = 1'b1;
        end else begin
            busy_o = 1'b0;
        end
        group_state_o = state_r;
        halt_set_o    = halt_set_r;
        bp_cause_o    = bp_cause_r;
        timeout_o     = timeout_r;
    end

endmodule

// File: tb/tb_adbg_cpu_halt_group_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for adbg_cpu_halt_group_ctrl (NB_CORES=4, HALT_TIMEOUT=8).
// Stimulus is applied on the falling edge; a reference model predicts the
// register-visible outputs after the next rising edge and queues them. A
// monitor samples the DUT 1 time unit after each rising edge and compares.
// ----------------------------------------------------------------------------
module tb_adbg_cpu_halt_group_ctrl;

    localparam int N = 4;
    localparam int T = 8;

    localparam int M_RUN      = 0;
    localparam int M_HALTING  = 1;
    localparam int M_HALTED   = 2;
    localparam int M_RESUMING = 3;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] group_mask_i = 4'b0000;
    logic [N-1:0] dbg_stall_req_i = 4'b0000;
    logic [N-1:0] cpu_bp_i = 4'b0000;
    logic [N-1:0] cpu_halted_i = 4'b0000;
    logic         halt_req_i = 1'b0;
    logic         resume_req_i = 1'b0;
    logic [N-1:0] cpu_stall_o;
    logic [1:0]   group_state_o;
    logic [N-1:0] halt_set_o;
    logic [N-1:0] bp_cause_o;
    logic         timeout_o;
    logic         busy_o;

    adbg_cpu_halt_group_ctrl #(.NB_CORES(N), .HALT_TIMEOUT(T)) dut (
        .cpu_clk_i       (clk),
        .rst_i           (rst_i),
        .group_mask_i    (group_mask_i),
        .dbg_stall_req_i (dbg_stall_req_i),
        .cpu_bp_i        (cpu_bp_i),
        .cpu_halted_i    (cpu_halted_i),
        .halt_req_i      (halt_req_i),
        .resume_req_i    (resume_req_i),
        .cpu_stall_o     (cpu_stall_o),
        .group_state_o   (group_state_o),
        .halt_set_o      (halt_set_o),
        .bp_cause_o      (bp_cause_o),
        .timeout_o       (timeout_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           st;
        logic [N-1:0] stall;
        logic [N-1:0] set;
        logic [N-1:0] cause;
        logic         to;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: phase, captured group, causes, timeout, cycles waited.
    int           m_mode = M_RUN;
    logic [N-1:0] m_set = 4'b0000;
    logic [N-1:0] m_cause = 4'b0000;
    logic         m_to = 1'b0;
    int           m_waited = 0;

    function automatic int stall_held(input int mode);
        return (mode == M_HALTING || mode == M_HALTED) ? 1 : 0;
    endfunction

    task automatic model_step();
        if (rst_i) begin
            m_mode = M_RUN; m_set = 4'b0000; m_cause = 4'b0000;
            m_to = 1'b0; m_waited = 0;
        end else if (m_mode == M_RUN) begin
            if (halt_req_i || ((cpu_bp_i & group_mask_i) != 4'b0000)) begin
                m_mode = M_HALTING; m_set = group_mask_i;
                m_cause = cpu_bp_i & group_mask_i; m_to = 1'b0; m_waited = 0;
            end
        end else if (m_mode == M_HALTING) begin
            m_cause = m_cause | (cpu_bp_i & m_set);
            m_waited = m_waited + 1;
            if ((cpu_halted_i & m_set) == m_set) begin
                m_mode = M_HALTED;
            end else if (m_waited >= T) begin
                m_mode = M_HALTED; m_to = 1'b1;
            end
        end else if (m_mode == M_HALTED) begin
            m_cause = m_cause | (cpu_bp_i & m_set);
            if (resume_req_i) begin
                m_mode = M_RESUMING; m_to = 1'b0; m_waited = 0;
            end
        end else begin
            m_waited = m_waited + 1;
            if ((cpu_halted_i & m_set) == 4'b0000) begin
                m_mode = M_RUN; m_set = 4'b0000;
            end else if (m_waited >= T) begin
                m_mode = M_RUN; m_set = 4'b0000; m_to = 1'b1;
            end
        end
    endtask

    // One clock of stimulus; the expected post-edge view goes to the scoreboard.
    task automatic cyc(input logic r, input logic [N-1:0] m, input logic [N-1:0] d,
                       input logic [N-1:0] b, input logic [N-1:0] h,
                       input logic hq, input logic rq);
        exp_t e;
        @(negedge clk);
        rst_i = r; group_mask_i = m; dbg_stall_req_i = d; cpu_bp_i = b;
        cpu_halted_i = h; halt_req_i = hq; resume_req_i = rq;
        model_step();
        e.st    = m_mode;
        e.stall = d | ((stall_held(m_mode) != 0) ? m_set : 4'b0000);
        e.set   = m_set;
        e.cause = m_cause;
        e.to    = m_to;
        e.busy  = (m_mode == M_HALTING || m_mode == M_RESUMING);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",    int'(group_state_o), e.st);
                chk("stall",    int'(cpu_stall_o),   int'(e.stall));
                chk("halt_set", int'(halt_set_o),    int'(e.set));
                chk("bp_cause", int'(bp_cause_o),    int'(e.cause));
                chk("timeout",  int'(timeout_o),     int'(e.to));
                chk("busy",     int'(busy_o),        int'(e.busy));
            end
        end
    end

    initial begin
        logic [N-1:0] h;
        logic [N-1:0] m;
        logic [N-1:0] b;
        logic [N-1:0] d;
        cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // Breakpoint on a group member, then full acknowledge.
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b0, 1'b0);
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b0, 1'b0);
        // Resume, cores linger halted a while, then leave.
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b0, 1'b1);
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b0, 1'b0);
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // Group halt with one core never acknowledging: HALTING timeout.
        cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 1'b1, 1'b0);
        for (int i = 0; i < T + 3; i++)
            cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 1'b0, 1'b0);
        // Halt and resume together in HALTED: resume wins; RESUMING timeout.
        cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 1'b1, 1'b1);
        for (int i = 0; i < T + 2; i++)
            cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 1'b0, 1'b0);
        // Breakpoint outside the group is ignored.
        cyc(1'b0, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0);
        // Manual stall with an empty-group halt.
        cyc(1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc(1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // Reset while HALTED releases the group immediately.
        cyc(1'b0, 4'b0011, 4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0100, 4'b0000, 4'b0011, 1'b0, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0100, 4'b0000, 4'b0011, 1'b0, 1'b0);
        cyc(1'b1, 4'b0011, 4'b0100, 4'b0000, 4'b0011, 1'b0, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0100, 4'b0000, 4'b0011, 1'b0, 1'b0);
        // Randomized traffic; halted acknowledges mostly persist so waits vary.
        h = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            m = 4'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            b = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 4) == 0) h = 4'($urandom);
            cyc(($urandom_range(0, 149) == 0), m, d, b, h,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end
        cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
